pll_reconfig_master: RTL and testbench
======================================

# pll_reconfig_master

Avalon-MM-controlled master that drives the reconfiguration port of the capture PLL. The HPS writes M, N and C0–C3 counter settings into shadow registers and sets a start bit. The block then sequences the writes onto the 64-bit `reconfig_to_pll` bus, polls `reconfig_from_pll` until the PLL reports completion, and waits for the PLL to lock, with a timeout. It sits between the HPS lightweight bridge and the PLL wrapper's reconfig interface.

## Interface
- `LOCK_TIMEOUT`, default 65535: cycles allowed for each wait phase (status poll, lock) before flagging an error.
- `clk` in 1: single clock; also drives the PLL management clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `avs_address` in 3: word address.
- `avs_read` in 1: Avalon read strobe.
- `avs_write` in 1: Avalon write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data; fixed read latency of 1 cycle.
- `avs_waitrequest` out 1: tied to 0.
- `reconfig_to_pll` out 64: bus fields are [0] mgmt_write, [1] mgmt_read, [7:2] mgmt_address, [39:8] mgmt_writedata; bits [63:40] are 0.
- `reconfig_from_pll` in 64: bus fields are [31:0] mgmt_readdata and [32] mgmt_waitrequest; other bits are ignored.
- `pll_locked` in 1: PLL lock, asynchronous; double-synchronised internally.

## Operation
- Register map (word address):
  - 0 CTRL. A write with bit0=1 starts a sequence. Read fields: [0] busy, [1] done, [2] error, [3] synchronised lock.
  - 1 M, 2 N, 3..6 C0..C3. Fields: [7:0] lo, [15:8] hi, [16] bypass, [17] odd. A hi or lo value of 0 means 256.
  - 7 reads 0.
- Shadow register reset values: M = 0x00001919, N = 0x00020302, C0–C3 = 0x00010000.
- Writes to addresses 1–6 while busy are ignored. A start while busy is ignored.
- A start clears done and error, and sets busy.
- PLL-side register addresses: 0 MODE, 1 STATUS, 2 START, 3 N, 4 M, 5 C.
  - For a C write, writedata[22:18] carries the counter index and [17:0] the shadow value.
- FSM states and transitions:
  - IDLE: wait for start.
  - MODE: write addr 0, data 1 (polling mode).
  - WR_N: write addr 3, data N.
  - WR_M: write addr 4, data M.
  - WR_C: write addr 5, idx k, for k = 0..3. Stay in WR_C until k=3 completes.
  - START: write addr 2, data 0.
  - POLL: read addr 1 until mgmt_readdata[0] = 1.
  - LOCK: wait for synchronised lock = 1.
  - Return to IDLE with done=1 and busy=0.
- Bus transaction rule:
  - mgmt_write or mgmt_read is asserted on state entry with address and data stable.
  - It is held until a cycle in which mgmt_waitrequest = 0 is sampled. That cycle completes the transaction.
  - The strobe deasserts, or the next transaction begins, on the following edge.
  - At most one of write/read is high at any time.
- POLL: each completed read with bit0 = 0 issues a new read on the next cycle.
- Timeout counter (17-bit):
  - Cleared on entry to POLL and on entry to LOCK; counts one per cycle in those states.
  - On reaching LOCK_TIMEOUT: error=1, done=1, busy=0, return to IDLE.
  - POLL timeout and LOCK timeout behave identically.
- If lock rises in the same cycle the counter hits the limit, lock wins: no error.

## Timing
- Reset (async assert):
  - FSM goes to IDLE; busy, done, error = 0.
  - `reconfig_to_pll` = 0 and `avs_readdata` = 0.
  - Shadow registers take their reset values.
- Reset mid-sequence aborts the sequence immediately; there is no partial-completion flag.
- Start latency: CTRL write at edge t puts MODE's mgmt_write high after edge t+1.
- With mgmt_waitrequest held at 0:
  - The 8 writes (MODE, N, M, C0–C3, START) take 8 consecutive cycles.
  - POLL's first read is in cycle 9.
- Busy reads 1 from the cycle after the start write until the cycle after the sequence finishes.
- `avs_readdata` is valid the cycle after `avs_read`, and reflects register state at the read edge.
- Lock synchroniser adds 2 cycles before LOCK observes `pll_locked`.

## Test plan
- Reset values:
  - Read addresses 0–6 after reset -> 0x0, 0x1919, 0x20302, 0x10000 ×4.
  - `reconfig_to_pll` = 0.
- Nominal sequence, waitrequest = 0:
  - Write M = 0x1414, then start.
  - Monitor sees writes (addr, data): (0,1), (3,0x20302), (4,0x1414), (5,0x10000|k<<18) for k = 0..3, then (2,0).
  - PLL model returns status 1 after 3 reads; lock rises 10 cycles later.
  - CTRL then reads 0x0A.
- Waitrequest stalls: hold mgmt_waitrequest = 1 for 5 cycles on the WR_M write -> address and data stay stable for 6 cycles; no write is skipped or duplicated.
- Lock timeout: LOCK_TIMEOUT = 100 and lock never rises -> CTRL = 0x06 exactly 100 cycles after entering LOCK.
- Busy protection: during a sequence, write C2 = 0xFFFF and issue a second start -> C2 still reads 0x10000; exactly one sequence runs.
- Reset mid-sequence: assert `reset_n` low during WR_C -> `reconfig_to_pll` = 0 asynchronously. After release, CTRL = 0 and shadow registers are back at reset values.

Source files
------------

// File: rtl/pll_reconfig_master.sv
// rtl/pll_reconfig_master.sv - Avalon-MM driven sequencer for the capture PLL reconfig port
module pll_reconfig_master #(
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [63:0] reconfig_to_pll,
  input  logic [63:0] reconfig_from_pll,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_WR_N, S_WR_M, S_WR_C, S_START, S_POLL, S_LOCK
  } state_t;

  localparam logic [16:0] LIMIT = 17'(LOCK_TIMEOUT);

  state_t      state, state_n;
  logic [1:0]  c_idx, c_idx_n;
  logic [16:0] tcnt, tcnt_n, tcnt_inc;
  logic [17:0] m_reg, n_reg;
  logic [17:0] c_reg [4];
  logic        busy, done, error, start_req;
  logic        lock_meta, lock_sync;
  logic        finish, timeout;
  logic        mgmt_write, mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        ctrl_start, shadow_wr, xfer_done;
  logic        unused_bits;

  assign avs_waitrequest = 1'b0;
  assign ctrl_start  = avs_write && (avs_address == 3'd0) && avs_writedata[0];
  assign shadow_wr   = avs_write && !busy && (avs_address != 3'd0) && (avs_address != 3'd7);
  assign xfer_done   = !reconfig_from_pll[32];
  assign tcnt_inc    = tcnt + 17'd1;
  assign unused_bits = &{1'b0, reconfig_from_pll[63:33], reconfig_from_pll[31:1], avs_writedata[31:18]};
  assign reconfig_to_pll = {24'd0, mgmt_writedata, mgmt_address, mgmt_read, mgmt_write};

  // Bring the asynchronous PLL lock into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // Shadow registers; frozen while a sequence is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg <= 18'h01919;
      n_reg <= 18'h20302;
      for (int i = 0; i < 4; i++) c_reg[i] <= 18'h10000;
    end else if (shadow_wr) begin
      case (avs_address)
        3'd1:    m_reg <= avs_writedata[17:0];
        3'd2:    n_reg <= avs_writedata[17:0];
        default: c_reg[2'(avs_address - 3'd3)] <= avs_writedata[17:0];
      endcase
    end
  end

  // Status flags; a start is deferred one cycle through start_req before MODE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      start_req <= 1'b0;
    end else begin
      start_req <= ctrl_start && !busy;
      if (ctrl_start && !busy) begin
        busy  <= 1'b1;
        done  <= 1'b0;
        error <= 1'b0;
      end else if (finish) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        error <= timeout;
      end
    end
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      case (avs_address)
        3'd0:    avs_readdata <= {28'd0, lock_sync, error, done, busy};
        3'd1:    avs_readdata <= {14'd0, m_reg};
        3'd2:    avs_readdata <= {14'd0, n_reg};
        3'd7:    avs_readdata <= 32'd0;
        default: avs_readdata <= {14'd0, c_reg[2'(avs_address - 3'd3)]};
      endcase
    end
  end

  // Sequencer state, counter index and wait-phase timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      c_idx <= 2'd0;
      tcnt  <= 17'd0;
    end else begin
      state <= state_n;
      c_idx <= c_idx_n;
      tcnt  <= tcnt_n;
    end
  end

  // Next state and bus drive; strobes are a pure function of state so reset clears them at once
  always_comb begin
    state_n        = state;
    c_idx_n        = c_idx;
    tcnt_n         = tcnt;
    finish         = 1'b0;
    timeout        = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    case (state)
      S_IDLE: begin
        if (start_req) state_n = S_MODE;
      end
      S_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_writedata = 32'd1;
        if (xfer_done) state_n = S_WR_N;
      end
      S_WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd3;
        mgmt_writedata = {14'd0, n_reg};
        if (xfer_done) state_n = S_WR_M;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd4;
        mgmt_writedata = {14'd0, m_reg};
        if (xfer_done) begin
          state_n = S_WR_C;
          c_idx_n = 2'd0;
        end
      end
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd5;
        mgmt_writedata = {9'd0, 3'd0, c_idx, c_reg[c_idx]};
        if (xfer_done) begin
          if (c_idx == 2'd3) state_n = S_START;
          else               c_idx_n = c_idx + 2'd1;
        end
      end
      S_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
        if (xfer_done) begin
          state_n = S_POLL;
          tcnt_n  = 17'd0;
        end
      end
      S_POLL: begin
        mgmt_read    = 1'b1;
        mgmt_address = 6'd1;
        if (xfer_done && reconfig_from_pll[0]) begin
          state_n = S_LOCK;
          tcnt_n  = 17'd0;
        end else if (tcnt_inc == LIMIT) begin
          state_n = S_IDLE;
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          tcnt_n = tcnt_inc;
        end
      end
      S_LOCK: begin
        if (lock_sync) begin
          state_n = S_IDLE;
          finish  = 1'b1;
        end else if (tcnt_inc == LIMIT) begin
          state_n = S_IDLE;
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          tcnt_n = tcnt_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// tb/tb_pll_reconfig_master.sv - directed vector bench for pll_reconfig_master
module tb_pll_reconfig_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [63:0] to_pll, from_pll;
  logic        pll_locked = 1'b0;

  always #5 clk = ~clk;

  pll_reconfig_master #(.LOCK_TIMEOUT(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .reconfig_to_pll(to_pll), .reconfig_from_pll(from_pll),
    .pll_locked(pll_locked)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // PLL model
  wire        mwr   = to_pll[0];
  wire        mrd   = to_pll[1];
  wire [5:0]  maddr = to_pll[7:2];
  wire [31:0] mdata = to_pll[39:8];
  int  reads_done = 0, lock_cnt = 0, stall_left = 0;
  bit  stall_arm = 0, lock_en = 1;
  wire mwait  = (stall_left != 0) && mwr && (maddr == 6'd4);
  wire status = (reads_done >= 2);
  assign from_pll = {31'd0, mwait, 31'd0, status};

  // Snapshot of the bus taken mid-cycle, consumed by the model at the edge
  bit s_wr, s_rd, s_wait, s_status;
  logic [5:0] s_addr;

  // Monitor log
  logic [5:0]  log_addr [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  int n_wr = 0, mode_cnt = 0, excl_err = 0;
  int m_cycles = 0, m_unstable = 0, first_rd = -1, lock_entry = 0;
  bit lock_seen = 0;
  logic [31:0] m_prev = 0;

  always @(negedge clk) begin
    s_wr = mwr; s_rd = mrd; s_addr = maddr; s_wait = mwait; s_status = status;
    if (mwr && mrd) excl_err++;
    if (mwr && maddr == 6'd0) begin
      mode_cnt++; m_cycles = 0; first_rd = -1; lock_seen = 0;
    end
    if (mwr && maddr == 6'd4) begin
      if (m_cycles > 0 && mdata != m_prev) m_unstable++;
      m_prev = mdata;
      m_cycles++;
    end
    if (mwr && !mwait && n_wr < 64) begin
      log_addr[n_wr] = maddr; log_data[n_wr] = mdata; log_cyc[n_wr] = cyc; n_wr++;
    end
    if (mrd && !mwait && first_rd < 0) first_rd = cyc;
    if (mrd && !mwait && status && !lock_seen) begin
      lock_seen = 1; lock_entry = cyc + 1;
    end
  end

  always @(posedge clk) begin
    if (s_wr && s_addr == 6'd0) begin
      reads_done <= 0; stall_left <= stall_arm ? 5 : 0; pll_locked <= 1'b0; lock_cnt <= 0;
    end else begin
      if (s_wait) stall_left <= stall_left - 1;
      if (s_rd && !s_wait) reads_done <= reads_done + 1;
      if (s_rd && !s_wait && s_status && lock_en) lock_cnt <= 10;
      else if (lock_cnt > 0) begin
        lock_cnt <= lock_cnt - 1;
        if (lock_cnt == 1) pll_locked <= 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1'b1; avs_address = a;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] d;
    int k;
    for (k = 0; k < 400; k++) begin
      avs_rd(3'd0, d);
      if (!d[0]) break;
    end
    check(nm, 64'(k < 400), 64'd1);
  endtask

  typedef struct { logic [2:0] addr; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_vec_t;
  rd_vec_t rv [8];
  wr_vec_t wv [8];

  initial begin
    logic [31:0] d;
    int base, modes, hit;
    bit found;

    rv[0] = '{3'd0, 32'h0};     rv[1] = '{3'd1, 32'h1919};
    rv[2] = '{3'd2, 32'h20302}; rv[3] = '{3'd3, 32'h10000};
    rv[4] = '{3'd4, 32'h10000}; rv[5] = '{3'd5, 32'h10000};
    rv[6] = '{3'd6, 32'h10000}; rv[7] = '{3'd7, 32'h0};
    wv[0] = '{6'd0, 32'h1};
    wv[1] = '{6'd3, 32'h20302};
    wv[2] = '{6'd4, 32'h1414};
    for (int k = 0; k < 4; k++) wv[3 + k] = '{6'd5, 32'h10000 | (k << 18)};
    wv[7] = '{6'd2, 32'h0};

    reset_n = 1'b0; avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    repeat (3) @(negedge clk);
    check("reset_readdata", 64'(avs_readdata), 64'd0);
    check("reset_to_pll", to_pll, 64'd0);
    reset_n = 1'b1;

    foreach (rv[i]) begin
      avs_rd(rv[i].addr, d);
      check($sformatf("reset_reg%0d", rv[i].addr), 64'(d), 64'(rv[i].exp));
    end

    // Run 1: nominal sequence
    avs_wr(3'd1, 32'h1414);
    base = n_wr;
    avs_wr(3'd0, 32'h1);
    check("start_lat_t1", 64'(to_pll[0]), 64'd0);
    @(negedge clk);
    check("start_lat_t2", 64'({to_pll[7:0]}), 64'h01);
    wait_idle("run1_idle");
    check("run1_nwr", 64'(n_wr - base), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("run1_addr%0d", i), 64'(log_addr[base + i]), 64'(wv[i].addr));
      check($sformatf("run1_data%0d", i), 64'(log_data[base + i]), 64'(wv[i].data));
      check($sformatf("run1_cyc%0d", i), 64'(log_cyc[base + i] - log_cyc[base]), 64'(i));
    end
    check("run1_first_read", 64'(first_rd - log_cyc[base]), 64'd8);
    avs_rd(3'd0, d);
    check("run1_ctrl", 64'(d), 64'h0A);

    // Run 2: waitrequest stall on M, plus writes while busy
    stall_arm = 1;
    base = n_wr;
    avs_wr(3'd0, 32'h1);
    avs_wr(3'd5, 32'hFFFF);
    avs_wr(3'd0, 32'h1);
    wait_idle("run2_idle");
    repeat (20) @(negedge clk);
    check("run2_nwr", 64'(n_wr - base), 64'd8);
    modes = 0;
    for (int i = base; i < n_wr; i++) if (log_addr[i] == 6'd0) modes++;
    check("run2_one_seq", 64'(modes), 64'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("run2_addr%0d", i), 64'(log_addr[base + i]), 64'(wv[i].addr));
      check($sformatf("run2_data%0d", i), 64'(log_data[base + i]), 64'(wv[i].data));
    end
    check("run2_m_cycles", 64'(m_cycles), 64'd6);
    check("run2_m_stable", 64'(m_unstable), 64'd0);
    avs_rd(3'd5, d);
    check("run2_c2_kept", 64'(d), 64'h10000);
    stall_arm = 0;

    // Run 3: lock never rises, timeout of 100 cycles
    lock_en = 0;
    avs_wr(3'd0, 32'h1);
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (mode_cnt == 3 && lock_seen) begin found = 1; break; end
    end
    check("run3_reach_lock", 64'(found), 64'd1);
    @(negedge clk);
    avs_read = 1'b1; avs_address = 3'd0;
    hit = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (avs_readdata == 32'h6) begin hit = cyc; break; end
    end
    avs_read = 1'b0;
    check("run3_ctrl_err", 64'(hit >= 0), 64'd1);
    check("run3_timeout_cyc", 64'(hit - lock_entry), 64'd101);

    // Run 4: reset during WR_C
    avs_wr(3'd1, 32'h0505);
    avs_wr(3'd0, 32'h1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mwr && maddr == 6'd5) begin found = 1; break; end
    end
    check("run4_reach_wrc", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    check("run4_async_clear", to_pll, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    avs_rd(3'd0, d);
    check("run4_ctrl", 64'(d), 64'h0);
    avs_rd(3'd1, d);
    check("run4_m_reset", 64'(d), 64'h1919);
    avs_rd(3'd5, d);
    check("run4_c2_reset", 64'(d), 64'h10000);
    repeat (5) @(negedge clk);
    check("run4_bus_idle", to_pll, 64'd0);

    check("strobe_exclusive", 64'(excl_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
